// File: rtl/rf_write_ctrl_pkg.sv
// Shared types and sizing for the register-file write controller.
// Holds the controller state encoding and the default register/data geometry.
package rf_ctrl_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 16;
  localparam int NREG   = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rf_write_ctrl_if.sv
// Requester and register-file write bundle for rf_write_ctrl.
// The master side issues writeback requests; the slave side is the controller.
interface rf_write_ctrl_if
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = rf_ctrl_pkg::DATA_W
);

  logic              a_valid;
  logic              a_ready;
  logic [REG_W-1:0]  a_reg;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [REG_W-1:0]  b_reg;
  logic [DATA_W-1:0] b_data;
  logic              wr_en;
  logic [REG_W-1:0]  wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic              init_done;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, wr_en, wr_reg, wr_data, init_done
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, wr_en, wr_reg, wr_data, init_done
  );

endinterface

// File: rtl/rf_write_ctrl_arb.sv
// Two-way round-robin arbiter: combinational grants, pointer flop remembers
// which requester was granted most recently.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

   logic lastB;

   always_comb begin
      // NOTE: assign every combinational output a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      gnt = 2'b00;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = lastB ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // A grant is only ever issued to a valid requester, so a grant is an
   // acceptance and the pointer moves only then.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: reset to "B last" so A wins the first tie after reset.
      if (!rst)        lastB <= 1'b1;
      else if (gnt[0]) lastB <= 1'b0;
      else if (gnt[1]) lastB <= 1'b1;
   end

endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write controller: clears registers 1..NREG-1 after reset,
// then arbitrates ALU and load writebacks onto the single write port.
module rf_write_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = rf_ctrl_pkg::DATA_W,
  parameter int NREG   = rf_ctrl_pkg::NREG
) (
  input logic              clk,
  input logic              rst,
  input logic              stall,
  rf_write_ctrl_if.slave   bus
);

   state_t            state, stateN;
   logic [REG_W-1:0]  cnt, cntN;
   logic              wrEn, wrEnN;
   logic [REG_W-1:0]  wrReg, wrRegN;
   logic [DATA_W-1:0] wrData, wrDataN;
   logic              initDone, initDoneN;
   logic [1:0]        gnt;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .en  (state == RUN && !stall),
      .req ({bus.b_valid, bus.a_valid}),
      .gnt (gnt)
   );

   assign bus.a_ready   = gnt[0];
   assign bus.b_ready   = gnt[1];
   assign bus.wr_en     = wrEn;
   assign bus.wr_reg    = wrReg;
   assign bus.wr_data   = wrData;
   assign bus.init_done = initDone;

   always_comb begin
      stateN    = state;
      cntN      = cnt;
      wrEnN     = 1'b0;
      wrRegN    = wrReg;
      wrDataN   = wrData;
      initDoneN = initDone;
      unique case (state)
         INIT: begin
            // The last clear write is on the bus this cycle; leave INIT now.
            if (wrEn && wrReg == REG_W'(NREG - 1)) begin
               stateN    = RUN;
               initDoneN = 1'b1;
            end else begin
               wrEnN   = 1'b1;
               wrRegN  = cnt;
               wrDataN = '0;
               cntN    = cnt + 4'd1;
            end
         end
         RUN: begin
            // Register 0 is hardwired zero: accept the request, drop the write.
            if (gnt[0] && bus.a_reg != '0) begin
               wrEnN   = 1'b1;
               wrRegN  = bus.a_reg;
               wrDataN = bus.a_data;
            end else if (gnt[1] && bus.b_reg != '0) begin
               wrEnN   = 1'b1;
               wrRegN  = bus.b_reg;
               wrDataN = bus.b_data;
            end
         end
         default: stateN = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= INIT;
         cnt      <= REG_W'(1);
         wrEn     <= 1'b0;
         wrReg    <= '0;
         wrData   <= '0;
         initDone <= 1'b0;
      end else begin
         // NOTE: state flops use non-blocking assignments so every flop
         // samples the values from before this edge.
         state    <= stateN;
         cnt      <= cntN;
         wrEn     <= wrEnN;
         wrReg    <= wrRegN;
         wrData   <= wrDataN;
         initDone <= initDoneN;
      end
   end

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed bench for rf_write_ctrl: clear sequence, arbitration vectors,
// and reset aborts during RUN and mid-INIT.
module tb_rf_write_ctrl;
   import rf_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic stall = 1'b0;
   int   total = 0;
   int   bad = 0;

   rf_write_ctrl_if #(.DATA_W(16)) bus ();

   rf_write_ctrl #(.DATA_W(16), .NREG(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        aV;
      logic [3:0]  aReg;
      logic [15:0] aData;
      logic        bV;
      logic [3:0]  bReg;
      logic [15:0] bData;
      logic        expAR;
      logic        expBR;
      logic        expWrEn;
      logic [3:0]  expWrReg;
      logic [15:0] expWrData;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(input logic st, input logic aV, input logic [3:0] aReg,
                               input logic [15:0] aData, input logic bV, input logic [3:0] bReg,
                               input logic [15:0] bData, input logic expAR, input logic expBR,
                               input logic expWrEn, input logic [3:0] expWrReg,
                               input logic [15:0] expWrData);
      vec_t v;
      v.st = st; v.aV = aV; v.aReg = aReg; v.aData = aData;
      v.bV = bV; v.bReg = bReg; v.bData = bData;
      v.expAR = expAR; v.expBR = expBR; v.expWrEn = expWrEn;
      v.expWrReg = expWrReg; v.expWrData = expWrData;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic idleInputs();
      stall = 1'b0;
      bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;
   endtask

   task automatic checkZeroed(input string tag);
      check({tag, " wr_en"}, 32'(bus.wr_en), 32'd0);
      check({tag, " wr_reg"}, 32'(bus.wr_reg), 32'd0);
      check({tag, " wr_data"}, 32'(bus.wr_data), 32'd0);
      check({tag, " init_done"}, 32'(bus.init_done), 32'd0);
      check({tag, " a_ready"}, 32'(bus.a_ready), 32'd0);
   endtask

   // Checks the clear writes 1..upto; a full run also checks the hand-off to RUN.
   task automatic runInit(input string tag, input int upto);
      for (int k = 1; k <= upto; k++) begin
         @(posedge clk); #1;
         check($sformatf("%s init%0d wr_en", tag, k), 32'(bus.wr_en), 32'd1);
         check($sformatf("%s init%0d wr_reg", tag, k), 32'(bus.wr_reg), 32'(k));
         check($sformatf("%s init%0d wr_data", tag, k), 32'(bus.wr_data), 32'd0);
         check($sformatf("%s init%0d init_done", tag, k), 32'(bus.init_done), 32'd0);
         check($sformatf("%s init%0d a_ready", tag, k), 32'(bus.a_ready), 32'd0);
         check($sformatf("%s init%0d b_ready", tag, k), 32'(bus.b_ready), 32'd0);
      end
      if (upto == 15) begin
         for (int k = 16; k <= 17; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s edge%0d wr_en", tag, k), 32'(bus.wr_en), 32'd0);
            check($sformatf("%s edge%0d init_done", tag, k), 32'(bus.init_done), 32'd1);
         end
      end
   endtask

   task automatic applyVec(input string tag, input vec_t v);
      stall = v.st;
      bus.a_valid = v.aV; bus.a_reg = v.aReg; bus.a_data = v.aData;
      bus.b_valid = v.bV; bus.b_reg = v.bReg; bus.b_data = v.bData;
      #1;
      check({tag, " a_ready"}, 32'(bus.a_ready), 32'(v.expAR));
      check({tag, " b_ready"}, 32'(bus.b_ready), 32'(v.expBR));
      @(posedge clk); #1;
      check({tag, " wr_en"}, 32'(bus.wr_en), 32'(v.expWrEn));
      check({tag, " wr_reg"}, 32'(bus.wr_reg), 32'(v.expWrReg));
      check({tag, " wr_data"}, 32'(bus.wr_data), 32'(v.expWrData));
   endtask

   initial begin
      //            st aV aReg aData     bV bReg bData     aR bR en reg wdata
      vecs[0]  = mk(0, 1, 2,  16'h1111, 1, 5,  16'h2222, 1, 0, 1, 2,  16'h1111);
      vecs[1]  = mk(0, 1, 2,  16'h1111, 1, 5,  16'h2222, 0, 1, 1, 5,  16'h2222);
      vecs[2]  = mk(0, 1, 2,  16'h1111, 1, 5,  16'h2222, 1, 0, 1, 2,  16'h1111);
      vecs[3]  = mk(0, 1, 2,  16'h1111, 1, 5,  16'h2222, 0, 1, 1, 5,  16'h2222);
      vecs[4]  = mk(0, 1, 3,  16'hBEEF, 0, 0,  16'h0000, 1, 0, 1, 3,  16'hBEEF);
      vecs[5]  = mk(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 0, 0, 3,  16'hBEEF);
      vecs[6]  = mk(0, 0, 0,  16'h0000, 1, 0,  16'hFFFF, 0, 1, 0, 3,  16'hBEEF);
      vecs[7]  = mk(0, 1, 2,  16'h1111, 1, 5,  16'h2222, 1, 0, 1, 2,  16'h1111);
      vecs[8]  = mk(1, 1, 9,  16'h1234, 0, 0,  16'h0000, 0, 0, 0, 2,  16'h1111);
      vecs[9]  = mk(1, 1, 9,  16'h1234, 0, 0,  16'h0000, 0, 0, 0, 2,  16'h1111);
      vecs[10] = mk(1, 1, 9,  16'h1234, 0, 0,  16'h0000, 0, 0, 0, 2,  16'h1111);
      vecs[11] = mk(0, 1, 9,  16'h1234, 0, 0,  16'h0000, 1, 0, 1, 9,  16'h1234);
      vecs[12] = mk(0, 1, 7,  16'hAAAA, 1, 4,  16'h4444, 0, 1, 1, 4,  16'h4444);
      vecs[13] = mk(0, 1, 0,  16'h5555, 0, 0,  16'h0000, 1, 0, 0, 4,  16'h4444);
      vecs[14] = mk(0, 1, 1,  16'h0001, 1, 15, 16'hF00F, 0, 1, 1, 15, 16'hF00F);
      vecs[15] = mk(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 0, 0, 15, 16'hF00F);

      idleInputs();
      rst = 1'b0;
      #3;
      checkZeroed("reset");
      @(negedge clk) rst = 1'b1;
      runInit("first", 15);

      for (int i = 0; i < 16; i++) applyVec($sformatf("vec%0d", i), vecs[i]);

      // Reset during RUN right after a write lands on the bus.
      bus.a_valid = 1'b1; bus.a_reg = 4'd6; bus.a_data = 16'h6666;
      #1;
      check("run a_ready", 32'(bus.a_ready), 32'd1);
      @(posedge clk); #1;
      check("run wr_en", 32'(bus.wr_en), 32'd1);
      check("run wr_reg", 32'(bus.wr_reg), 32'd6);
      rst = 1'b0;
      #1;
      checkZeroed("runabort");
      @(negedge clk) rst = 1'b1;
      runInit("midinit", 7);

      // Reset mid-INIT while register 7 is being cleared.
      rst = 1'b0;
      #1;
      checkZeroed("initabort");
      idleInputs();
      @(negedge clk) rst = 1'b1;
      runInit("restart", 15);

      // Pointer was "A last" before the resets; a reset must restore A priority.
      applyVec("posttie", mk(0, 1, 2, 16'h1111, 1, 5, 16'h2222, 1, 0, 1, 2, 16'h1111));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
